// File: rtl/rupt_ctrl_if.sv
// Signal bundle between the pipeline and the interrupt controller.
// The controller takes the slave view, the pipeline/driver the master view.
interface rupt_ctrl_if #(
    parameter int NRUPT = 10
);
    logic [NRUPT-1:0] rupt_req;
    logic             inhint;
    logic             relint;
    logic             resume;
    logic             ovf_a;
    logic             extend_pending;
    logic             index_pending;
    logic             stall;
    logic [11:0]      pc_D;
    logic             hold_fetch;
    logic             save_en;
    logic [11:0]      save_pc;
    logic             redirect;
    logic             flush;
    logic [11:0]      vector;
    logic [NRUPT-1:0] ack;
    logic             in_rupt;

    modport slave (
        input  rupt_req, inhint, relint, resume, ovf_a,
        input  extend_pending, index_pending, stall, pc_D,
        output hold_fetch, save_en, save_pc, redirect, flush,
        output vector, ack, in_rupt
    );

    modport master (
        output rupt_req, inhint, relint, resume, ovf_a,
        output extend_pending, index_pending, stall, pc_D,
        input  hold_fetch, save_en, save_pc, redirect, flush,
        input  vector, ack, in_rupt
    );
endinterface

// File: rtl/rupt_ctrl.sv
// Interrupt sequencer: latches request pulses, picks the lowest pending source,
// drains the pipeline, saves the return PC, redirects to the vector, waits for RESUME.
module rupt_ctrl #(
    parameter int          NRUPT      = 10,
    parameter logic [11:0] VEC_BASE   = 12'o4004,
    parameter int          VEC_STRIDE = 4
) (
    input  logic     clock,
    input  logic     rst_l,
    rupt_ctrl_if.slave bus
);
    localparam int SELW = (NRUPT > 1) ? $clog2(NRUPT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        SAVE   = 3'd2,
        VECTOR = 3'd3,
        ACTIVE = 3'd4
    } state_t;

    state_t           state_r;
    logic [NRUPT-1:0] pending_r;
    logic [NRUPT-1:0] ack_r;
    logic             inhint_q_r;
    logic [SELW-1:0]  sel_r;
    logic             hold_fetch_r;
    logic             save_en_r;
    logic [11:0]      save_pc_r;
    logic             redirect_r;
    logic             flush_r;
    logic [11:0]      vector_r;
    logic             in_rupt_r;

    logic             eligible_s;
    logic [SELW-1:0]  prio_s;
    logic [11:0]      vec_s;
    logic [NRUPT-1:0] ack_onehot_s;

    function automatic logic [SELW-1:0] lowest_idx(input logic [NRUPT-1:0] v);
        lowest_idx = '0;
        for (int i = NRUPT - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_idx = SELW'(i);
            end
        end
    endfunction

    // Service eligibility, priority pick and the vector/ack for the latched source.
    always_comb begin
        eligible_s = 1'b0;
        if (state_r == IDLE) begin
            eligible_s = (|pending_r) & ~inhint_q_r & ~bus.ovf_a;
        end else begin
            eligible_s = 1'b0;
        end
        prio_s       = lowest_idx(pending_r);
        vec_s        = VEC_BASE + 12'(VEC_STRIDE) * 12'(sel_r);
        ack_onehot_s = NRUPT'(1) << sel_r;
    end

    // Pending latch; a new pulse wins over the ack that would clear it.
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            pending_r <= '0;
        end else begin
            pending_r <= (pending_r & ~ack_r) | bus.rupt_req;
        end
    end

    // INHINT/RELINT mask; simultaneous pulses cancel out.
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            inhint_q_r <= 1'b0;
        end else begin
            case ({bus.inhint, bus.relint})
                2'b10:   inhint_q_r <= 1'b1;
                2'b01:   inhint_q_r <= 1'b0;
                default: inhint_q_r <= inhint_q_r;
            endcase
        end
    end

    // Sequencer; outputs are registered alongside the state they belong to.
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            state_r      <= IDLE;
            sel_r        <= '0;
            hold_fetch_r <= 1'b0;
            save_en_r    <= 1'b0;
            save_pc_r    <= 12'd0;
            redirect_r   <= 1'b0;
            flush_r      <= 1'b0;
            vector_r     <= 12'd0;
            ack_r        <= '0;
            in_rupt_r    <= 1'b0;
        end else begin
            hold_fetch_r <= 1'b0;
            save_en_r    <= 1'b0;
            save_pc_r    <= 12'd0;
            redirect_r   <= 1'b0;
            flush_r      <= 1'b0;
            vector_r     <= 12'd0;
            ack_r        <= '0;
            in_rupt_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (eligible_s) begin
                        state_r      <= DRAIN;
                        sel_r        <= prio_s;
                        hold_fetch_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DRAIN: begin
                    hold_fetch_r <= 1'b1;
                    if (!bus.stall && !bus.extend_pending && !bus.index_pending) begin
                        state_r   <= SAVE;
                        save_en_r <= 1'b1;
                        // decode is frozen by hold_fetch, so pc_D is stable here
                        save_pc_r <= bus.pc_D;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                SAVE: begin
                    state_r    <= VECTOR;
                    redirect_r <= 1'b1;
                    flush_r    <= 1'b1;
                    vector_r   <= vec_s;
                    ack_r      <= ack_onehot_s;
                end
                VECTOR: begin
                    state_r   <= ACTIVE;
                    in_rupt_r <= 1'b1;
                end
                ACTIVE: begin
                    if (bus.resume) begin
                        state_r <= IDLE;
                    end else begin
                        state_r   <= ACTIVE;
                        in_rupt_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.hold_fetch = hold_fetch_r;
    assign bus.save_en    = save_en_r;
    assign bus.save_pc    = save_pc_r;
    assign bus.redirect   = redirect_r;
    assign bus.flush      = flush_r;
    assign bus.vector     = vector_r;
    assign bus.ack        = ack_r;
    assign bus.in_rupt    = in_rupt_r;
endmodule

// File: tb/tb_rupt_ctrl.sv
// Directed bench for rupt_ctrl: each service sequence is checked cycle by cycle
// against hand-computed vectors, save PCs and acks.
module tb_rupt_ctrl;
    logic clock = 1'b0;
    logic rst_l;
    int   n_vec = 0;
    int   n_bad = 0;

    rupt_ctrl_if #(.NRUPT(10)) bus ();

    rupt_ctrl #(
        .NRUPT(10),
        .VEC_BASE(12'o4004),
        .VEC_STRIDE(4)
    ) dut (
        .clock(clock),
        .rst_l(rst_l),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %o expected %o", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_req(input logic [9:0] v);
        bus.rupt_req = v;
        step();
        bus.rupt_req = 10'd0;
    endtask

    task automatic idle_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check({tag, ".hold"}, 12'(bus.hold_fetch), 12'd0);
            check({tag, ".ack"}, 12'(bus.ack), 12'd0);
        end
    endtask

    // From DRAIN: SAVE, VECTOR, then first ACTIVE cycle.
    task automatic svc_tail(input string tag, input logic [11:0] pcv, input int src,
                            input logic [11:0] vec, input logic rereq);
        logic [9:0] oh;
        oh = 10'd1 << src;
        step();
        check({tag, ".save_en"}, 12'(bus.save_en), 12'd1);
        check({tag, ".save_pc"}, bus.save_pc, pcv);
        check({tag, ".save_hold"}, 12'(bus.hold_fetch), 12'd1);
        step();
        if (rereq) bus.rupt_req = oh;
        else bus.rupt_req = 10'd0;
        check({tag, ".redirect"}, 12'(bus.redirect), 12'd1);
        check({tag, ".flush"}, 12'(bus.flush), 12'd1);
        check({tag, ".ack"}, 12'(bus.ack), 12'(oh));
        check({tag, ".vector"}, bus.vector, vec);
        check({tag, ".vec_save_en"}, 12'(bus.save_en), 12'd0);
        step();
        bus.rupt_req = 10'd0;
        check({tag, ".in_rupt"}, 12'(bus.in_rupt), 12'd1);
        check({tag, ".act_redirect"}, 12'(bus.redirect), 12'd0);
        check({tag, ".act_ack"}, 12'(bus.ack), 12'd0);
        check({tag, ".act_vector"}, bus.vector, 12'd0);
    endtask

    // Called in the cycle where the request is eligible in IDLE.
    task automatic svc(input string tag, input logic [11:0] pcv, input int src,
                       input logic [11:0] vec, input logic rereq);
        step();
        check({tag, ".drain_hold"}, 12'(bus.hold_fetch), 12'd1);
        check({tag, ".drain_save_en"}, 12'(bus.save_en), 12'd0);
        svc_tail(tag, pcv, src, vec, rereq);
    endtask

    task automatic do_resume(input string tag);
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        check({tag, ".resume"}, 12'(bus.in_rupt), 12'd0);
    endtask

    initial begin
        rst_l              = 1'b0;
        bus.rupt_req       = 10'd0;
        bus.inhint         = 1'b0;
        bus.relint         = 1'b0;
        bus.resume         = 1'b0;
        bus.ovf_a          = 1'b0;
        bus.extend_pending = 1'b0;
        bus.index_pending  = 1'b0;
        bus.stall          = 1'b0;
        bus.pc_D           = 12'o2345;

        // reset: outputs quiet, requests seen during reset are dropped
        step();
        bus.rupt_req = 10'h3ff;
        step();
        bus.rupt_req = 10'd0;
        check("rst.hold", 12'(bus.hold_fetch), 12'd0);
        check("rst.save_en", 12'(bus.save_en), 12'd0);
        check("rst.redirect", 12'(bus.redirect), 12'd0);
        check("rst.in_rupt", 12'(bus.in_rupt), 12'd0);
        check("rst.ack", 12'(bus.ack), 12'd0);
        check("rst.vector", bus.vector, 12'd0);
        rst_l = 1'b1;
        idle_quiet("rst_rel", 3);

        // single source 3
        pulse_req(10'b0000001000);
        svc("src3", 12'o2345, 3, 12'o4020, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("src3.hold_in_rupt", 12'(bus.in_rupt), 12'd1);
        end
        do_resume("src3");
        idle_quiet("src3_after", 2);

        // 7 and 2 together: 2 first, 7 after resume
        bus.pc_D = 12'o1000;
        pulse_req(10'b0010000100);
        svc("pri2", 12'o1000, 2, 12'o4014, 1'b0);
        do_resume("pri2");
        svc("pri7", 12'o1000, 7, 12'o4040, 1'b0);
        do_resume("pri7");

        // INHINT defers until RELINT
        bus.pc_D   = 12'o0777;
        bus.inhint = 1'b1;
        step();
        bus.inhint = 1'b0;
        pulse_req(10'b0000000001);
        idle_quiet("inh", 3);
        bus.relint = 1'b1;
        step();
        bus.relint = 1'b0;
        svc("inh_rel", 12'o0777, 0, 12'o4004, 1'b0);
        do_resume("inh_rel");

        // overflow in A defers likewise
        bus.ovf_a = 1'b1;
        pulse_req(10'b0000000001);
        idle_quiet("ovf", 3);
        bus.ovf_a = 1'b0;
        svc("ovf_clr", 12'o0777, 0, 12'o4004, 1'b0);
        do_resume("ovf_clr");

        // extend_pending for 4 DRAIN cycles; late inhint/ovf/resume must not abort
        bus.pc_D = 12'o3210;
        pulse_req(10'b0000010000);
        step();
        bus.extend_pending = 1'b1;
        bus.ovf_a          = 1'b1;
        bus.inhint         = 1'b1;
        bus.resume         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ext.hold", 12'(bus.hold_fetch), 12'd1);
            check("ext.save_en", 12'(bus.save_en), 12'd0);
            step();
            bus.inhint = 1'b0;
            bus.resume = 1'b0;
        end
        bus.extend_pending = 1'b0;
        bus.ovf_a          = 1'b0;
        check("ext.last_hold", 12'(bus.hold_fetch), 12'd1);
        check("ext.last_save_en", 12'(bus.save_en), 12'd0);
        svc_tail("ext", 12'o3210, 4, 12'o4024, 1'b0);
        bus.relint = 1'b1;
        step();
        bus.relint = 1'b0;
        check("ext.still_active", 12'(bus.in_rupt), 12'd1);
        do_resume("ext");
        idle_quiet("ext_after", 2);

        // request coinciding with its own ack stays pending
        bus.pc_D = 12'o0123;
        pulse_req(10'b0000100000);
        svc("ack5a", 12'o0123, 5, 12'o4030, 1'b1);
        do_resume("ack5a");
        svc("ack5b", 12'o0123, 5, 12'o4030, 1'b0);
        do_resume("ack5b");
        idle_quiet("ack5_after", 2);

        // reset during ACTIVE with source 1 still pending
        pulse_req(10'b0000000011);
        svc("pre_rst", 12'o0123, 0, 12'o4004, 1'b0);
        #2;
        rst_l = 1'b0;
        #1;
        check("mid_rst.in_rupt", 12'(bus.in_rupt), 12'd0);
        check("mid_rst.hold", 12'(bus.hold_fetch), 12'd0);
        step();
        step();
        rst_l = 1'b1;
        idle_quiet("post_rst", 5);
        pulse_req(10'b0000000010);
        svc("src1", 12'o0123, 1, 12'o4010, 1'b0);
        do_resume("src1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/rupt_ctrl.md
RUPT_CTRL -- requirements
Module: rupt_ctrl

Interface
REQ-001 Parameter NRUPT, default 10, the number of interrupt sources.
REQ-002 Parameter VEC_BASE, default 12'o4004, the vector of source 0.
REQ-003 Parameter VEC_STRIDE, default 4, the vector spacing between sources.
REQ-004 Port clock, input, 1: the single clock; all flops are rising-edge.
REQ-005 Port rst_l, input, 1: reset, asynchronous, active-low.
REQ-006 Port rupt_req, input, NRUPT: one-cycle request pulses, one bit per source.
REQ-007 Port inhint, input, 1: pulse; an INHINT instruction has retired.
REQ-008 Port relint, input, 1: pulse; a RELINT instruction has retired.
REQ-009 Port resume, input, 1: pulse; a RESUME instruction has retired.
REQ-010 Port ovf_a, input, 1: the A register holds overflow.
REQ-011 Port extend_pending, input, 1: an EXTEND prefix is in flight.
REQ-012 Port index_pending, input, 1: an INDEX prefix is in flight.
REQ-013 Port stall, input, 1: the pipeline is stalled.
REQ-014 Port pc_D, input, 12: PC of the instruction in decode.
REQ-015 Port hold_fetch, output, 1: freezes fetch.
REQ-016 Port save_en, output, 1: write save_pc to the ZRUPT save register.
REQ-017 Port save_pc, output, 12: the return address.
REQ-018 Port redirect, output, 1: branch fetch to vector.
REQ-019 Port flush, output, 1: flush the fetch and decode stages.
REQ-020 Port vector, output, 12: the interrupt target address.
REQ-021 Port ack, output, NRUPT: one-hot acknowledge of the serviced source.
REQ-022 Port in_rupt, output, 1: an interrupt service routine is active.

Function
REQ-023 pending[NRUPT-1:0] SHALL set a bit when the matching rupt_req bit is 1 and clear it when the matching ack bit is 1; set and ack of the same bit in one cycle SHALL leave the bit set.
REQ-024 inhint_q SHALL set on inhint and clear on relint; if both pulse in one cycle, inhint_q SHALL be unchanged.
REQ-025 eligible SHALL equal |pending & ~inhint_q & ~ovf_a, evaluated only in state IDLE.
REQ-026 Priority SHALL be fixed, with the lowest index winning; the chosen index sel SHALL be latched on IDLE->DRAIN and held until ACTIVE.
REQ-027 The FSM SHALL have the states IDLE, DRAIN, SAVE, VECTOR and ACTIVE; each state holds unless a listed transition fires.
REQ-028 IDLE->DRAIN SHALL occur when eligible is 1.
REQ-029 DRAIN SHALL assert hold_fetch and go to SAVE when stall, extend_pending and index_pending are all 0.
REQ-030 SAVE SHALL last exactly one cycle, assert hold_fetch and save_en with save_pc=pc_D, then go to VECTOR.
REQ-031 VECTOR SHALL last exactly one cycle, assert redirect, flush and ack[sel], drive vector=VEC_BASE+VEC_STRIDE*sel (12-bit, truncated), then go to ACTIVE.
REQ-032 ACTIVE SHALL assert in_rupt and go to IDLE on resume; requests arriving while the FSM is not IDLE SHALL stay pending.
REQ-033 All outputs not asserted by the current state SHALL be 0, with vector and save_pc driving 0.
REQ-034 Minimum latency SHALL be 3 cycles: eligible seen in IDLE at cycle T gives save_en at T+2 and redirect at T+3.
REQ-035 inhint, relint or ovf_a changing after IDLE->DRAIN SHALL NOT abort the sequence.
REQ-036 A resume received outside ACTIVE SHALL be ignored.

Reset
REQ-037 While rst_l=0, the FSM SHALL be IDLE, pending SHALL be 0, inhint_q SHALL be 0, sel SHALL be 0, and every output SHALL be 0, independent of clock.
REQ-038 Reset asserted mid-sequence (DRAIN, SAVE, VECTOR or ACTIVE) SHALL discard the sequence and the pending requests; no ack SHALL be issued.

Verification
REQ-039 rupt_req=10'b0000001000 pulse, pc_D=12'o2345, no stall -> save_en with save_pc=12'o2345 at T+2; redirect, flush, ack[3] and vector=12'o4020 at T+3; in_rupt follows until resume.
REQ-040 rupt_req bits 7 and 2 pulse in the same cycle -> source 2 is serviced first with vector 12'o4014; after resume, source 7 is serviced with vector 12'o4040.
REQ-041 inhint pulse, then rupt_req[0] -> no hold_fetch while inhint_q is set; relint -> the sequence starts with vector 12'o4004; ovf_a=1 likewise defers the request.
REQ-042 extend_pending=1 for 4 cycles after DRAIN entry -> hold_fetch stays asserted 4 extra cycles and save_en is delayed accordingly; then the normal sequence completes.
REQ-043 rupt_req[5] pulse coinciding with ack[5] -> pending[5] remains 1 and a second service of source 5 follows resume.
REQ-044 rst_l driven low during ACTIVE with pending[1]=1 -> in_rupt drops immediately; after release, no request fires without a new pulse.
